csr_access_arbiter: RTL and testbench
=====================================

# csr_access_arbiter

Controller that owns the 64-bit cycle/instret counters and `mcountinhibit`, and shares them between two requesters: the pipeline's EX-stage CSR instruction port and a debug access port. It:
- arbitrates between the two ports;
- sequences each access as a fixed 3-state transaction (read, modify, write, respond);
- decodes CSR addresses and flags illegal accesses;
- gates counter increments on inhibit, retire and flush.

It sits beside the pipeline's EX stage and replaces direct counter reads by the datapath.

## Interface
- `RR_EN`, default 1: 1 gives round-robin arbitration between core and debug; 0 gives fixed core priority.
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous and active-low.
- `core_req` input 1: core CSR request, held until `core_gnt`.
- `core_op` input 2: `csr_op_e` (RW=1, RS=2, RC=3; 0 is illegal).
- `core_addr` input 12: CSR address.
- `core_wdata` input 32: rs1/uimm operand.
- `core_flush` input 1: pipeline flush, aborts an in-flight core access.
- `core_gnt` output 1: one-cycle grant pulse.
- `core_rvalid` output 1: one-cycle response pulse.
- `core_rdata` output 32: old CSR value, valid with `core_rvalid`.
- `core_err` output 1: illegal access, valid with `core_rvalid`.
- `dbg_req`, `dbg_we`, `dbg_addr[11:0]`, `dbg_wdata[31:0]`: inputs. Debug request; `dbg_we`=1 is a plain write, 0 is a read.
- `dbg_gnt`, `dbg_rvalid`, `dbg_rdata[31:0]`, `dbg_err`: outputs, same meaning as the core versions.
- `retire` input 1: one instruction retires this cycle.

## Operation
- Address map:
  - 0xC00/0xC80 cycle lo/hi, read-only;
  - 0xC02/0xC82 instret lo/hi, read-only;
  - 0xB00/0xB80 mcycle lo/hi, read-write;
  - 0xB02/0xB82 minstret lo/hi, read-write;
  - 0x320 mcountinhibit, read-write, bits [0] and [2] only, other bits read 0.
- FSM states IDLE, BUSY, RESP:
  - IDLE → BUSY when any request is pending. Latch the owner, op, addr and wdata.
  - BUSY → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Arbitration, applied in IDLE only:
  - Single requester wins.
  - When both request: with `RR_EN`=1 the port not granted last wins (pointer resets to "debug last", so core wins first); with `RR_EN`=0 core wins.
- Modify in BUSY, where old = the current CSR value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Debug write: new = wdata.
- Write suppression:
  - RS/RC with wdata=0 perform no write, and no error on a read-only CSR.
  - Debug read performs no write.
- Error, reported with rvalid, with no write performed:
  - unmapped address;
  - write to addr[11:10]==2'b11;
  - `core_op`=0.
  - On error, rdata=0.
- Counters, applied every cycle:
  - cycle += 1 unless inhibit[0].
  - instret += 1 when `retire` and not `core_flush`, unless inhibit[2].
- A CSR write to a counter half in the same cycle as an increment: the write wins for that half. The other half keeps its value and takes no carry.
- 64-bit counters wrap modulo 2^64. Carry from lo to hi is internal and never lost.

## Timing
- Reset values:
  - counters 0, inhibit 0, state IDLE;
  - all gnt/rvalid/err 0, rdata 0.
- Cycle 0: `req` sampled high in IDLE. Cycle 1: BUSY, `gnt` high. Cycle 2: RESP, `rvalid` high.
- Request-to-response latency is 2 cycles. Maximum throughput is 1 access per 3 cycles.
- The CSR write takes effect at the clock edge ending BUSY. Counter reads return the value present during BUSY.
- The requester must drop `req` in the cycle after `gnt`. A `req` still high in RESP is ignored; it is re-arbitrated from IDLE.
- `core_flush` while the core owns BUSY: no write, no `core_rvalid`, FSM still passes through RESP silently.
- `core_flush` while the core owns RESP: the response is still delivered.
- `rdata`/`err` are registered and change only at BUSY→RESP. They hold their value otherwise.
- Asynchronous reset mid-transaction: immediate return to IDLE with all outputs 0. A write not yet applied is lost.

## Structure
- Package `csr_pkg`:
  - `csr_op_e`;
  - `arb_state_e` {IDLE, BUSY, RESP};
  - the CSR address localparams;
  - inhibit bit indices.
- Sub-module `csr_counter64`, instantiated twice:
  - inputs: inc, inhibit, wr_lo, wr_hi, wdata;
  - output: 64-bit value;
  - asynchronous active-low reset.
- Arbiter FSM, decode and read/modify/write logic stay in the top.

## Test plan
- Reset, then idle 10 cycles, then debug read 0xC00 → `dbg_rvalid` at cycle +2, `dbg_rdata` = count consistent with the cycle of BUSY. No gnt/rvalid during reset.
- Both ports request simultaneously and repeatedly (`RR_EN`=1) → grants alternate core, dbg, core. With `RR_EN`=0 → core always wins.
- Core RS 0x320 wdata=0x1 → rdata 0, cycle then frozen. RC 0x320 wdata=0x1 → counting resumes.
- Debug write 0xB00 = 0xFFFFFFFF, with high half previously 0 → next cycle lo wraps to 0 and hi=1. A write to 0xB82 concurrent with `retire` → written value held, no increment on that half.
- Core RW to 0xC02 → `core_err`=1, rdata 0, instret unchanged. Core RS 0xC02 wdata=0 → no error, returns instret.
- Core RW 0xB00 with `core_flush` asserted during BUSY → no write, no `core_rvalid`. `retire` asserted together with `core_flush` → instret unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// Purpose: shared types and constants for the CSR access arbiter slice.
// Latency: n/a (types, address map and inhibit bit positions only).
// Backpressure: n/a.
package csr_pkg;

    // Core-side CSR instruction operation; 0 never encodes a legal access.
    typedef enum logic [1:0] {
        OP_ILL = 2'd0,
        OP_RW  = 2'd1,
        OP_RS  = 2'd2,
        OP_RC  = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // User-level read-only counter views
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    // Machine-level writable counter views
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // Implemented mcountinhibit bits
    localparam int INH_CY = 0;
    localparam int INH_IR = 2;

endpackage

// File: rtl/csr_counter64.sv
// Purpose: 64-bit free-running counter with independently writable 32-bit halves.
// Latency: increment or write visible one cycle after the qualifying edge.
// Backpressure: none; a write to either half drops that cycle's increment.
//
// Ports: clk, rst (async active-low), inc (count request), inhibit (freeze),
//        wr_lo/wr_hi (load wdata into the low/high half), value (current count).
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] value_inc;

    // Full 64-bit add so the lo->hi carry can never be dropped.
    assign value_inc = value + 64'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (wr_lo || wr_hi) begin
            // Software write wins; the untouched half holds and takes no carry.
            if (wr_lo) value[31:0]  <= wdata;
            if (wr_hi) value[63:32] <= wdata;
        end else if (inc && !inhibit) begin
            value <= value_inc;
        end
    end

endmodule

// File: rtl/csr_access_arbiter.sv
// Purpose: owns cycle/instret/mcountinhibit and serves core + debug CSR ports.
// Latency: grant 1 cycle after req is sampled in IDLE, response 2 cycles; 1 access / 3 cycles.
// Backpressure: requester holds req until gnt; a port not granted simply waits in IDLE.
//
// Ports: clk, rst (async active-low);
//        core_req/op/addr/wdata/flush -> core_gnt/rvalid/rdata/err;
//        dbg_req/we/addr/wdata        -> dbg_gnt/rvalid/rdata/err;
//        retire (one instruction retired this cycle).
module csr_access_arbiter
    import csr_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [1:0]  core_op,
    input  logic [11:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_flush,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [11:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    input  logic        retire
);

    arb_state_e  state;
    logic        own_dbg;
    logic        last_dbg;
    csr_op_e     op_q;
    logic        we_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;

    logic        inh_cy;
    logic        inh_ir;
    logic [63:0] cycle_val;
    logic [63:0] instret_val;

    logic        pick_dbg;
    logic        mapped;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        wants_write;
    logic        acc_err;
    logic        core_abort;
    logic        do_write;
    logic        wr_cy_lo, wr_cy_hi, wr_ir_lo, wr_ir_hi, wr_inh;

    // Debug wins when alone, or on a tie when round-robin says core went last.
    assign pick_dbg = dbg_req && (!core_req || (RR_EN && !last_dbg));

    // Read decode on the latched address; counter halves are shared by both views.
    always_comb begin
        old_val = '0;
        mapped  = 1'b1;
        case (addr_q)
            CSR_CYCLE,    CSR_MCYCLE:    old_val = cycle_val[31:0];
            CSR_CYCLEH,   CSR_MCYCLEH:   old_val = cycle_val[63:32];
            CSR_INSTRET,  CSR_MINSTRET:  old_val = instret_val[31:0];
            CSR_INSTRETH, CSR_MINSTRETH: old_val = instret_val[63:32];
            CSR_MCOUNTINHIBIT:           old_val = {29'b0, inh_ir, 1'b0, inh_cy};
            default:                     mapped  = 1'b0;
        endcase
    end

    // RS/RC with a zero mask are pure reads, so they are legal on read-only CSRs.
    assign wants_write = own_dbg ? we_q
                                 : ((op_q == OP_RW) ||
                                    (((op_q == OP_RS) || (op_q == OP_RC)) && (wdata_q != '0)));

    assign acc_err = !mapped
                  || (wants_write && (addr_q[11:10] == 2'b11))
                  || (!own_dbg && (op_q == OP_ILL));

    assign core_abort = !own_dbg && core_flush;
    assign do_write   = (state == BUSY) && wants_write && !acc_err && !core_abort;

    always_comb begin
        new_val = wdata_q;
        if (!own_dbg) begin
            case (op_q)
                OP_RS:   new_val = old_val | wdata_q;
                OP_RC:   new_val = old_val & ~wdata_q;
                default: new_val = wdata_q;
            endcase
        end
    end

    assign wr_cy_lo = do_write && (addr_q == CSR_MCYCLE);
    assign wr_cy_hi = do_write && (addr_q == CSR_MCYCLEH);
    assign wr_ir_lo = do_write && (addr_q == CSR_MINSTRET);
    assign wr_ir_hi = do_write && (addr_q == CSR_MINSTRETH);
    assign wr_inh   = do_write && (addr_q == CSR_MCOUNTINHIBIT);

    csr_counter64 u_cycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .inhibit (inh_cy),
        .wr_lo   (wr_cy_lo),
        .wr_hi   (wr_cy_hi),
        .wdata   (new_val),
        .value   (cycle_val)
    );

    // A flushed instruction never counts as retired.
    csr_counter64 u_instret (
        .clk     (clk),
        .rst     (rst),
        .inc     (retire && !core_flush),
        .inhibit (inh_ir),
        .wr_lo   (wr_ir_lo),
        .wr_hi   (wr_ir_hi),
        .wdata   (new_val),
        .value   (instret_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (wr_inh) begin
            inh_cy <= new_val[INH_CY];
            inh_ir <= new_val[INH_IR];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            own_dbg     <= 1'b0;
            last_dbg    <= 1'b1;   // core wins the first tie
            op_q        <= OP_ILL;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_gnt    <= 1'b0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            core_err    <= 1'b0;
            dbg_gnt     <= 1'b0;
            dbg_rvalid  <= 1'b0;
            dbg_rdata   <= '0;
            dbg_err     <= 1'b0;
        end else begin
            core_gnt    <= 1'b0;
            dbg_gnt     <= 1'b0;
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req || dbg_req) begin
                        state    <= BUSY;
                        own_dbg  <= pick_dbg;
                        last_dbg <= pick_dbg;
                        op_q     <= csr_op_e'(core_op);
                        we_q     <= dbg_we;
                        addr_q   <= pick_dbg ? dbg_addr  : core_addr;
                        wdata_q  <= pick_dbg ? dbg_wdata : core_wdata;
                        if (pick_dbg) dbg_gnt  <= 1'b1;
                        else          core_gnt <= 1'b1;
                    end
                end
                BUSY: begin
                    state <= RESP;
                    if (own_dbg) begin
                        dbg_rvalid <= 1'b1;
                        dbg_rdata  <= acc_err ? '0 : old_val;
                        dbg_err    <= acc_err;
                    end else if (!core_flush) begin
                        // A flushed core access passes through RESP silently.
                        core_rvalid <= 1'b1;
                        core_rdata  <= acc_err ? '0 : old_val;
                        core_err    <= acc_err;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Purpose: directed scoreboard bench for csr_access_arbiter (round-robin and fixed-priority builds).
// Latency: stimulus expects grant 1 cycle and response 2 cycles after request.
// Backpressure: requests are held until grant, then dropped.
module tb_csr_access_arbiter;
    import csr_pkg::*;

    localparam int KIND_FIX = 0;
    localparam int KIND_LO  = 1;
    localparam int KIND_HI  = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0;
    logic [1:0]  core_op = 2'd0;
    logic [11:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_flush = 1'b0;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [11:0] dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        retire = 1'b0;

    // Fixed-priority build shares all data inputs, owns its own requests.
    logic        fx_core_req = 1'b0;
    logic        fx_dbg_req = 1'b0;
    logic        fx_core_gnt, fx_core_rvalid, fx_core_err;
    logic [31:0] fx_core_rdata;
    logic        fx_dbg_gnt, fx_dbg_rvalid, fx_dbg_err;
    logic [31:0] fx_dbg_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int fx_resp = 0;
    exp_t core_q[$];
    exp_t dbg_q[$];

    // Cycle-counter model: value right after edge base_edge is base.
    longint unsigned edges = 0;
    longint unsigned base_edge = 0;
    logic [63:0]     base = '0;
    bit              frozen = 1'b0;
    longint unsigned resp_edge = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rst) edges <= edges + 1;

    csr_access_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_op(core_op), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_flush(core_flush),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .retire(retire)
    );

    csr_access_arbiter #(.RR_EN(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .core_req(fx_core_req), .core_op(core_op), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_flush(core_flush),
        .core_gnt(fx_core_gnt), .core_rvalid(fx_core_rvalid), .core_rdata(fx_core_rdata), .core_err(fx_core_err),
        .dbg_req(fx_dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(fx_dbg_gnt), .dbg_rvalid(fx_dbg_rvalid), .dbg_rdata(fx_dbg_rdata), .dbg_err(fx_dbg_err),
        .retire(retire)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] model_cycle(input longint unsigned at_edge);
        if (frozen) return base;
        return base + 64'(at_edge - base_edge);
    endfunction

    // Scoreboard monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (core_rvalid) begin
                if (core_q.size() == 0) begin
                    check("core_unexpected_rvalid", 1, 0);
                end else begin
                    e = core_q.pop_front();
                    check("core_rdata", core_rdata, e.rdata);
                    check("core_err", core_err, e.err);
                end
            end
            if (dbg_rvalid) begin
                if (dbg_q.size() == 0) begin
                    check("dbg_unexpected_rvalid", 1, 0);
                end else begin
                    e = dbg_q.pop_front();
                    check("dbg_rdata", dbg_rdata, e.rdata);
                    check("dbg_err", dbg_err, e.err);
                end
            end
            if (fx_core_rvalid) begin
                fx_resp++;
                check("fx_core_resp", {fx_core_err, fx_core_rdata}, 0);
            end
            if (fx_dbg_rvalid) begin
                fx_resp++;
                check("fx_dbg_resp", {fx_dbg_err, fx_dbg_rdata}, 0);
            end
        end
    end

    // One access on the main instance. For debug, op==OP_RW means write, anything else read.
    task automatic access(input bit dbg, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input int kind, input logic [31:0] exp_val,
                          input bit exp_err, input bit flush_busy, input bit retire_busy);
        int n;
        logic [63:0] cv;
        exp_t e;
        @(negedge clk);
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = (op == OP_RW); dbg_addr = addr; dbg_wdata = wd;
        end else begin
            core_req = 1'b1; core_op = op; core_addr = addr; core_wdata = wd;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dbg ? dbg_gnt : core_gnt) && n < 20);
        check("gnt_latency", n, 1);
        dbg_req = 1'b0;
        core_req = 1'b0;
        if (n >= 20) return;
        cv = model_cycle(edges);
        case (kind)
            KIND_LO: e.rdata = cv[31:0];
            KIND_HI: e.rdata = cv[63:32];
            default: e.rdata = exp_val;
        endcase
        e.err = exp_err;
        if (!flush_busy) begin
            if (dbg) dbg_q.push_back(e);
            else     core_q.push_back(e);
        end
        core_flush = flush_busy;
        retire     = retire_busy;
        @(negedge clk);
        core_flush = 1'b0;
        retire     = 1'b0;
        resp_edge  = edges;
        check("rvalid_at_plus2", dbg ? dbg_rvalid : core_rvalid, !flush_busy);
        @(negedge clk);
        check("rvalid_one_pulse", dbg ? dbg_rvalid : core_rvalid, 0);
    endtask

    // Both ports keep requesting until each has had 3 grants; records grant order.
    task automatic contend(input bit fixed, input string exp_order);
        int cp = 3;
        int dp = 3;
        int steps = 0;
        string got = "";
        exp_t e;
        e.rdata = '0;
        e.err   = 1'b0;
        @(negedge clk);
        core_op = OP_RS; core_addr = CSR_MCOUNTINHIBIT; core_wdata = '0;
        dbg_we = 1'b0; dbg_addr = CSR_MCOUNTINHIBIT; dbg_wdata = '0;
        if (fixed) begin fx_core_req = 1'b1; fx_dbg_req = 1'b1; end
        else       begin core_req = 1'b1; dbg_req = 1'b1; end
        while ((cp > 0 || dp > 0) && steps < 60) begin
            @(negedge clk);
            steps++;
            if (fixed ? fx_core_gnt : core_gnt) begin
                got = {got, "c"}; cp--;
                if (!fixed) core_q.push_back(e);
                if (fixed) fx_core_req = 1'b0; else core_req = 1'b0;
            end else begin
                if (fixed) fx_core_req = (cp > 0); else core_req = (cp > 0);
            end
            if (fixed ? fx_dbg_gnt : dbg_gnt) begin
                got = {got, "d"}; dp--;
                if (!fixed) dbg_q.push_back(e);
                if (fixed) fx_dbg_req = 1'b0; else dbg_req = 1'b0;
            end else begin
                if (fixed) fx_dbg_req = (dp > 0); else dbg_req = (dp > 0);
            end
        end
        core_req = 1'b0; dbg_req = 1'b0; fx_core_req = 1'b0; fx_dbg_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got != exp_order) begin
            n_bad++;
            $display("FAIL grant_order(%s): got %s, expected %s", fixed ? "fixed" : "rr", got, exp_order);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Requests held during reset must not be granted.
        rst = 1'b0;
        core_req = 1'b1; dbg_req = 1'b1; core_op = OP_RW; core_addr = CSR_MCYCLE;
        repeat (3) @(negedge clk);
        check("rst_core_gnt", core_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_dbg_rvalid", dbg_rvalid, 0);
        check("rst_core_err", core_err, 0);
        check("rst_dbg_err", dbg_err, 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        core_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Counter read returns the count during BUSY.
        access(1, 2'd0, CSR_CYCLE, 0, KIND_LO, 0, 0, 0, 0);
        access(1, 2'd0, CSR_CYCLEH, 0, KIND_FIX, 0, 0, 0, 0);

        // Arbitration under contention.
        contend(0, "cdcdcd");
        contend(1, "cccddd");

        // Inhibit cycle, check it is frozen, then release.
        access(0, OP_RS, CSR_MCOUNTINHIBIT, 32'h1, KIND_FIX, 0, 0, 0, 0);
        base = model_cycle(resp_edge); base_edge = resp_edge; frozen = 1'b1;
        repeat (5) @(negedge clk);
        access(1, 2'd0, CSR_CYCLE, 0, KIND_LO, 0, 0, 0, 0);
        access(1, 2'd0, CSR_MCOUNTINHIBIT, 0, KIND_FIX, 32'h1, 0, 0, 0);
        access(0, OP_RC, CSR_MCOUNTINHIBIT, 32'h1, KIND_FIX, 32'h1, 0, 0, 0);
        base_edge = resp_edge; frozen = 1'b0;
        repeat (4) @(negedge clk);
        access(0, OP_RS, CSR_CYCLE, 0, KIND_LO, 0, 0, 0, 0);

        // Low half write just below wrap: carry lands in the high half.
        access(1, OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, KIND_LO, 0, 0, 0, 0);
        base = 64'h0000_0000_FFFF_FFFF; base_edge = resp_edge;
        access(1, 2'd0, CSR_MCYCLEH, 0, KIND_FIX, 32'h1, 0, 0, 0);
        access(1, 2'd0, CSR_MCYCLE, 0, KIND_LO, 0, 0, 0, 0);
        access(0, OP_RS, CSR_CYCLEH, 0, KIND_FIX, 32'h1, 0, 0, 0);

        // instret: one retire, then illegal and legal accesses to the read-only view.
        access(0, OP_RS, CSR_MCOUNTINHIBIT, 0, KIND_FIX, 0, 0, 0, 1);
        access(0, OP_RW, CSR_INSTRET, 32'h5, KIND_FIX, 0, 1, 0, 0);
        access(0, OP_RS, CSR_INSTRET, 0, KIND_FIX, 32'h1, 0, 0, 0);
        access(0, OP_RS, CSR_INSTRET, 32'h1, KIND_FIX, 0, 1, 0, 0);

        // Flushed core write: no response, no write, flushed retire not counted.
        access(0, OP_RW, CSR_MCYCLE, 32'h1234, KIND_FIX, 0, 0, 1, 1);
        access(1, 2'd0, CSR_MCYCLE, 0, KIND_LO, 0, 0, 0, 0);
        access(1, 2'd0, CSR_INSTRET, 0, KIND_FIX, 32'h1, 0, 0, 0);

        // High-half write racing a retire: written value sticks.
        access(1, OP_RW, CSR_MINSTRETH, 32'h55, KIND_FIX, 0, 0, 0, 1);
        access(1, 2'd0, CSR_INSTRETH, 0, KIND_FIX, 32'h55, 0, 0, 0);

        // Error sources.
        access(1, 2'd0, 12'h123, 0, KIND_FIX, 0, 1, 0, 0);
        access(0, OP_ILL, CSR_MCOUNTINHIBIT, 0, KIND_FIX, 0, 1, 0, 0);
        access(1, OP_RW, CSR_CYCLE, 32'h5, KIND_FIX, 0, 1, 0, 0);

        repeat (4) @(negedge clk);
        check("core_q_drained", core_q.size(), 0);
        check("dbg_q_drained", dbg_q.size(), 0);
        check("fx_responses", fx_resp, 6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
